// File: rtl/spi_mem_pkg.sv
// Shared constants for the SPI burst memory: FSM state encoding and burst counter sizing.
package spi_mem_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_ADDR      = 3'd1;
    localparam logic [STATE_W-1:0] ST_DECODE    = 3'd2;
    localparam logic [STATE_W-1:0] ST_RD_FETCH  = 3'd3;
    localparam logic [STATE_W-1:0] ST_RD_SHIFT  = 3'd4;
    localparam logic [STATE_W-1:0] ST_WR_SHIFT  = 3'd5;
    localparam logic [STATE_W-1:0] ST_WR_COMMIT = 3'd6;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE      = ST_IDLE,
        S_ADDR      = ST_ADDR,
        S_DECODE    = ST_DECODE,
        S_RD_FETCH  = ST_RD_FETCH,
        S_RD_SHIFT  = ST_RD_SHIFT,
        S_WR_SHIFT  = ST_WR_SHIFT,
        S_WR_COMMIT = ST_WR_COMMIT
    } state_t;

    localparam int             BURST_W   = 8;
    localparam logic [BURST_W-1:0] BURST_MAX = 8'd255;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/inputconditioner.sv
// Pin conditioner: 2-flop synchroniser, DEBOUNCE-cycle stability filter, 1-clk edge pulses.
module inputconditioner #(
    parameter int   DEBOUNCE  = 3,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic pos,
    output logic neg
);
    localparam int            CW   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] LOAD = CW'(DEBOUNCE - 1);

    logic          sync1, sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= RESET_VAL;
            sync2 <= RESET_VAL;
            level <= RESET_VAL;
            cnt   <= LOAD;
            pos   <= 1'b0;
            neg   <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            pos   <= 1'b0;
            neg   <= 1'b0;
            // down-counter runs only while the synced pin disagrees with the accepted level
            if (sync2 == level) begin
                cnt <= LOAD;
            end else if (cnt == '0) begin
                level <= sync2;
                pos   <= sync2;
                neg   <= ~sync2;
                cnt   <= LOAD;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/spi_frame_shifter.sv
// Width-N shift register with parallel load and a down-counting frame bit counter.
module spi_frame_shifter #(
    parameter int N     = 8,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] frame_len,
    input  logic             load,
    input  logic [N-1:0]     load_val,
    input  logic             shift_en,
    input  logic             ser_in,
    input  logic             count_en,
    output logic [N-1:0]     word,
    output logic             done
);
    logic [CNT_W-1:0] cnt;

    // done fires on the counting edge that consumes the last bit of the frame
    assign done = count_en && (cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            word <= '0;
            cnt  <= '0;
        end else begin
            if (load)
                word <= load_val;
            else if (shift_en)
                word <= {word[N-2:0], ser_in};

            if (start)
                cnt <= frame_len;
            else if (count_en && cnt != '0)
                cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_mem_burst.sv
// SPI-slave register memory with auto-incrementing bursts while CS is held low.
// Optional stuck-at-1 write fault on bit 0 when FAULT_INJECT_EN is defined.
//
// state      | meaning
// IDLE       | waiting for CS to fall
// ADDR       | shifting address + R/W bit
// DECODE     | latch address, choose read or write
// RD_FETCH   | 2 clk: memory read, then load shifter
// RD_SHIFT   | drive MISO on sclk negedges
// WR_SHIFT   | collect MOSI data word
// WR_COMMIT  | store word, advance address
module spi_mem_burst
    import spi_mem_pkg::*;
#(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int DEBOUNCE = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sclk_pin,
    input  logic               cs_pin,
    input  logic               mosi_pin,
`ifdef FAULT_INJECT_EN
    input  logic               faultinjector_pin,
`endif
    output logic               miso_pin,
    output logic               miso_oe,
    output logic               busy,
    output logic [STATE_W-1:0] state,
    output logic [BURST_W-1:0] burst_cnt
`ifdef FAULT_INJECT_EN
    , output logic             fault_seen
`endif
);
    localparam int SH_W  = max_int(ADDR_W + 1, DATA_W);
    localparam int CNT_W = $clog2(SH_W + 1);

    logic sclk_lvl, sclk_pos, sclk_neg;
    logic cs_lvl, cs_pos, cs_neg;
    logic mosi_lvl, mosi_pos, mosi_neg;

    inputconditioner #(.DEBOUNCE(DEBOUNCE), .RESET_VAL(1'b0)) u_sclk (
        .clk(clk), .reset(reset), .pin(sclk_pin), .level(sclk_lvl), .pos(sclk_pos), .neg(sclk_neg));
    inputconditioner #(.DEBOUNCE(DEBOUNCE), .RESET_VAL(1'b1)) u_cs (
        .clk(clk), .reset(reset), .pin(cs_pin), .level(cs_lvl), .pos(cs_pos), .neg(cs_neg));
    inputconditioner #(.DEBOUNCE(DEBOUNCE), .RESET_VAL(1'b0)) u_mosi (
        .clk(clk), .reset(reset), .pin(mosi_pin), .level(mosi_lvl), .pos(mosi_pos), .neg(mosi_neg));

    state_t              st;
    logic [ADDR_W-1:0]   addr_q;
    logic                fetch_ph;
    logic [DATA_W-1:0]   rd_data;
    logic [DATA_W-1:0]   wr_word;
    logic                mem_we;
    logic [DATA_W-1:0]   mem [0:(1 << ADDR_W) - 1];

    logic                sh_start, sh_load, sh_shift, sh_count, sh_done;
    logic [CNT_W-1:0]    sh_len;
    logic [SH_W-1:0]     sh_word;

`ifdef FAULT_INJECT_EN
    logic fault_lvl, fault_pos, fault_neg;
    inputconditioner #(.DEBOUNCE(DEBOUNCE), .RESET_VAL(1'b0)) u_fault (
        .clk(clk), .reset(reset), .pin(faultinjector_pin), .level(fault_lvl), .pos(fault_pos), .neg(fault_neg));
    assign wr_word = {sh_word[DATA_W-1:1], sh_word[0] | fault_lvl};
    logic unused_edges;
    assign unused_edges = ^{sclk_lvl, cs_pos, mosi_pos, mosi_neg, fault_pos, fault_neg};
`else
    assign wr_word = sh_word[DATA_W-1:0];
    logic unused_edges;
    assign unused_edges = ^{sclk_lvl, cs_pos, mosi_pos, mosi_neg};
`endif

    assign state = st;
    assign busy  = (st != S_IDLE);

    always_comb begin
        sh_start = 1'b0;
        sh_len   = CNT_W'(DATA_W);
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_count = 1'b0;
        case (st)
            S_IDLE: begin
                sh_start = cs_neg;
                sh_len   = CNT_W'(ADDR_W + 1);
            end
            S_DECODE, S_WR_COMMIT: sh_start = 1'b1;
            S_RD_FETCH: begin
                sh_start = 1'b1;
                sh_load  = fetch_ph;
            end
            S_ADDR, S_WR_SHIFT: begin
                sh_shift = sclk_pos && !cs_lvl;
                sh_count = sclk_pos && !cs_lvl;
            end
            // read data leaves on negedges, but the frame is still counted on posedges
            S_RD_SHIFT: begin
                sh_shift = sclk_neg && !cs_lvl;
                sh_count = sclk_pos && !cs_lvl;
            end
            default: ;
        endcase
    end

    spi_frame_shifter #(.N(SH_W), .CNT_W(CNT_W)) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .start    (sh_start),
        .frame_len(sh_len),
        .load     (sh_load),
        .load_val (SH_W'(rd_data)),
        .shift_en (sh_shift),
        .ser_in   (mosi_lvl),
        .count_en (sh_count),
        .word     (sh_word),
        .done     (sh_done)
    );

    assign mem_we = (st == S_WR_COMMIT) && !cs_lvl && !reset;

    // memory has no reset so its contents survive both reset and aborted bursts
    always_ff @(posedge clk) begin
        rd_data <= mem[addr_q];
        if (mem_we)
            mem[addr_q] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= S_IDLE;
            addr_q    <= '0;
            fetch_ph  <= 1'b0;
            burst_cnt <= '0;
            miso_pin  <= 1'b0;
            miso_oe   <= 1'b0;
`ifdef FAULT_INJECT_EN
            fault_seen <= 1'b0;
`endif
        end else if (st != S_IDLE && cs_lvl) begin
            st        <= S_IDLE;
            fetch_ph  <= 1'b0;
            burst_cnt <= '0;
            miso_pin  <= 1'b0;
            miso_oe   <= 1'b0;
        end else begin
            case (st)
                S_IDLE: begin
                    burst_cnt <= '0;
                    if (cs_neg)
                        st <= S_ADDR;
                end
                S_ADDR: if (sh_done) st <= S_DECODE;
                S_DECODE: begin
                    addr_q <= sh_word[ADDR_W:1];
                    if (sh_word[0]) begin
                        st      <= S_RD_FETCH;
                        miso_oe <= 1'b1;
                    end else begin
                        st <= S_WR_SHIFT;
                    end
                end
                S_RD_FETCH: begin
                    fetch_ph <= ~fetch_ph;
                    if (fetch_ph)
                        st <= S_RD_SHIFT;
                end
                S_RD_SHIFT: begin
                    if (sclk_neg)
                        miso_pin <= sh_word[DATA_W-1];
                    if (sh_done) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        if (burst_cnt != BURST_MAX)
                            burst_cnt <= burst_cnt + BURST_W'(1);
                        st <= S_RD_FETCH;
                    end
                end
                S_WR_SHIFT: if (sh_done) st <= S_WR_COMMIT;
                S_WR_COMMIT: begin
                    addr_q <= addr_q + ADDR_W'(1);
                    if (burst_cnt != BURST_MAX)
                        burst_cnt <= burst_cnt + BURST_W'(1);
`ifdef FAULT_INJECT_EN
                    if (fault_lvl && !sh_word[0])
                        fault_seen <= 1'b1;
`endif
                    st <= S_WR_SHIFT;
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule
